// File: rtl/text_buffer_pkg.sv
// text_buffer_pkg: shared definitions for the character-cell text buffer.
//   cmd_op_e : command engine op codes (CLEAR, FILL, SCROLL_UP, reserved)
//   state_e  : command engine FSM states
//   start_state(): first engine state for an accepted command
package text_buffer_pkg;

    typedef enum logic [1:0] {
        CMD_CLEAR  = 2'b00,
        CMD_FILL   = 2'b01,
        CMD_SCROLL = 2'b10,
        CMD_RSVD   = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWEEP,
        S_SHIFT,
        S_TAIL,
        S_DONE
    } state_e;

    // A single-row screen has nothing to shift, so SCROLL_UP only refills the row.
    // The reserved op is accepted and finishes straight away.
    function automatic state_e start_state(input cmd_op_e op, input logic single_row);
        state_e s;
        if (op == CMD_SCROLL)
            s = single_row ? S_TAIL : S_SHIFT;
        else if (op == CMD_RSVD)
            s = S_DONE;
        else
            s = S_SWEEP;
        return s;
    endfunction

endpackage

// File: rtl/text_buffer_dpram.sv
// text_buffer_dpram: cell RAM with one display read port and one engine/host port.
//   clk, rst          : clock; async reset clears only the display output register
//   a_addr / a_data   : display read, registered, read-first
//   b_raddr / b_rdata : engine read, registered, read-first
//   b_we, b_waddr, b_wdata : single write port
// Contents are never reset so the array maps onto block RAM.
module text_buffer_dpram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] a_data,
    input  logic [ADDR_W-1:0] b_raddr,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_waddr,
    input  logic [DATA_W-1:0] b_wdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            a_data <= '0;
        else
            a_data <= mem[a_addr];
    end

    always_ff @(posedge clk) begin
        b_rdata <= mem[b_raddr];
        if (b_we)
            mem[b_waddr] <= b_wdata;
    end

endmodule

// File: rtl/text_buffer.sv
// text_buffer: character-cell text buffer between the host register block and the renderer.
//   clk, rst                : clock, async active-high reset
//   rd_addr / rd_data       : display read port {row,col}, 1-cycle latency, never blocked
//   wr_en, wr_addr, wr_data : host cell write, ignored while busy (flagged by wr_drop)
//   cmd_valid/cmd_ready     : command handshake; cmd_op, cmd_fill latched on accept
//   busy, done              : engine active / 1-cycle completion pulse
// Cell = {attr, char}. The engine sweeps one cell per clock for CLEAR/FILL/SCROLL_UP.
module text_buffer
    import text_buffer_pkg::*;
#(
    parameter int TEXT_WIDTH     = 16,
    parameter int TEXT_HEIGHT    = 16,
    parameter int CHAR_BITS      = 8,
    parameter int ATTR_BITS      = 4,
    parameter int CLEAR_ON_RESET = 1,
    localparam int CELL_W = CHAR_BITS + ATTR_BITS,
    localparam int ADDR_W = $clog2(TEXT_WIDTH) + $clog2(TEXT_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CELL_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CELL_W-1:0] wr_data,
    output logic              wr_drop,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CELL_W-1:0] cmd_fill,
    output logic              busy,
    output logic              done
);

    localparam int N  = TEXT_WIDTH * TEXT_HEIGHT;
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] ROW_W      = CW'(TEXT_WIDTH);
    localparam logic [CW-1:0] SWEEP_LAST = CW'(N - 1);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(N - TEXT_WIDTH);
    localparam logic [CW-1:0] TAIL_BASE  = CW'(N - TEXT_WIDTH);
    localparam logic [CW-1:0] TAIL_LAST  = CW'(TEXT_WIDTH - 1);

    state_e            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [CELL_W-1:0] fill, fill_n;
    logic              init_pend;
    logic              idle_like;
    logic              accept;
    logic              b_we;
    logic [ADDR_W-1:0] b_waddr, b_raddr;
    logic [CELL_W-1:0] b_wdata, b_rdata;

    assign busy      = (state == S_SWEEP) || (state == S_SHIFT) || (state == S_TAIL);
    assign done      = (state == S_DONE);
    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    // The power-up clear owns the first cycle after reset, so no command is taken then.
    assign cmd_ready = !busy && !init_pend;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            fill      <= '0;
            init_pend <= (CLEAR_ON_RESET != 0);
            wr_drop   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            fill      <= fill_n;
            init_pend <= 1'b0;
            wr_drop   <= wr_en && busy;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fill_n  = fill;
        b_we    = 1'b0;
        b_waddr = wr_addr;
        b_wdata = wr_data;
        b_raddr = '0;
        case (state)
            S_IDLE, S_DONE: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                b_we    = wr_en;
                if (init_pend) begin
                    state_n = S_SWEEP;
                    fill_n  = '0;
                end else if (accept) begin
                    state_n = start_state(cmd_op_e'(cmd_op), TEXT_HEIGHT == 1);
                    fill_n  = (cmd_op == CMD_CLEAR) ? '0 : cmd_fill;
                end
            end
            S_SWEEP: begin
                b_we    = 1'b1;
                b_waddr = ADDR_W'(cnt);
                b_wdata = fill;
                cnt_n   = (cnt == SWEEP_LAST) ? '0 : cnt + ONE;
                state_n = (cnt == SWEEP_LAST) ? S_DONE : S_SWEEP;
            end
            S_SHIFT: begin
                // Read one row below at cnt, write it back one row up the next clock.
                // The final read (cnt == SHIFT_LAST) is a don't-care.
                b_raddr = ADDR_W'(cnt + ROW_W);
                b_we    = (cnt != '0);
                b_waddr = ADDR_W'(cnt - ONE);
                b_wdata = b_rdata;
                cnt_n   = (cnt == SHIFT_LAST) ? '0 : cnt + ONE;
                state_n = (cnt == SHIFT_LAST) ? S_TAIL : S_SHIFT;
            end
            S_TAIL: begin
                b_we    = 1'b1;
                b_waddr = ADDR_W'(TAIL_BASE + cnt);
                b_wdata = fill;
                cnt_n   = (cnt == TAIL_LAST) ? '0 : cnt + ONE;
                state_n = (cnt == TAIL_LAST) ? S_DONE : S_TAIL;
            end
            default: state_n = S_IDLE;
        endcase
    end

    text_buffer_dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (CELL_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .a_addr  (rd_addr),
        .a_data  (rd_data),
        .b_raddr (b_raddr),
        .b_rdata (b_rdata),
        .b_we    (b_we),
        .b_waddr (b_waddr),
        .b_wdata (b_wdata)
    );

endmodule

// File: tb/tb_text_buffer.sv
// tb_text_buffer: randomized self-checking bench for text_buffer against a screen-level model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_text_buffer;

    localparam int W  = 16;
    localparam int H  = 16;
    localparam int N  = W * H;
    localparam int CW = 12;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rd_addr = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [CW-1:0] rd_data;
    logic [CW-1:0] wr_data = '0;
    logic [CW-1:0] cmd_fill = '0;
    logic          wr_en = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = '0;
    logic          wr_drop, cmd_ready, busy, done;

    logic [CW-1:0] model [N];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    text_buffer #(
        .TEXT_WIDTH     (W),
        .TEXT_HEIGHT    (H),
        .CHAR_BITS      (8),
        .ATTR_BITS      (4),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_drop   (wr_drop),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_fill  (cmd_fill),
        .busy      (busy),
        .done      (done)
    );

    function automatic void model_fill(input logic [CW-1:0] f);
        for (int i = 0; i < N; i++) model[i] = f;
    endfunction

    // Screen scrolls up by one text row; the freed bottom row takes the fill cell.
    function automatic void model_scroll(input logic [CW-1:0] f);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (r < H - 1) model[r*W + c] = model[(r+1)*W + c];
                else model[r*W + c] = f;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_cell(input logic [AW-1:0] a, output logic [CW-1:0] v);
        rd_addr = a;
        cyc();
        v = rd_data;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [CW-1:0] f,
                           output int nb, output int nd, output logic bz);
        cmd_op = op;
        cmd_fill = f;
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        nb = 0;
        nd = 0;
        bz = 1'b0;
        for (int i = 0; i < 4*N; i++) begin
            if (done) begin
                nd++;
                bz = busy;
                cyc();
                if (done) nd++;
                break;
            end
            if (busy) nb++;
            cyc();
        end
    endtask

    task automatic test_reset();
        int nb;
        logic seen;
        logic [CW-1:0] v;
        rst = 1'b1;
        cyc();
        cyc();
        n_chk++;
        if ({busy, done, wr_drop} !== 3'b000 || rd_data !== '0)
            $display("FAIL reset_outputs: busy=%b done=%b wr_drop=%b rd_data=%h, want 0 0 0 000", busy, done, wr_drop, rd_data);
        else n_pass++;
        rst = 1'b0;
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 4*N; i++) begin
            cyc();
            if (done) begin seen = 1'b1; break; end
            if (busy) nb++;
        end
        n_chk++;
        if (!seen || nb != N) $display("FAIL reset_clear_busy: busy %0d clks done_seen=%b, want %0d 1", nb, seen, N);
        else n_pass++;
        cyc();
        n_chk++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL reset_clear_end: done=%b cmd_ready=%b, want 0 1", done, cmd_ready);
        else n_pass++;
        model_fill('0);
        for (int i = 0; i < N; i++) begin
            read_cell(AW'(i), v);
            n_chk++;
            if (v !== model[i]) $display("FAIL reset_cell[%0d]: got %h want %h", i, v, model[i]);
            else n_pass++;
        end
    endtask

    task automatic test_host_write();
        rd_addr = 8'h25;
        wr_en = 1'b1;
        wr_addr = 8'h25;
        wr_data = 12'h341;
        cyc();
        wr_en = 1'b0;
        n_chk++;
        if (rd_data !== model[8'h25]) $display("FAIL collision_read_first: got %h want %h", rd_data, model[8'h25]);
        else n_pass++;
        model[8'h25] = 12'h341;
        cyc();
        n_chk++;
        if (rd_data !== 12'h341) $display("FAIL write_then_read: got %h want 341", rd_data);
        else n_pass++;
    endtask

    task automatic test_random_rw();
        logic [CW-1:0] exp;
        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] ra, wa;
            wa = AW'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
            rd_addr = ra;
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = wa;
            wr_data = CW'($urandom);
            exp = model[ra];
            if (wr_en) model[wa] = wr_data;
            cyc();
            n_chk++;
            if (rd_data !== exp || wr_drop !== 1'b0)
                $display("FAIL random_rw[%0d] addr %h: rd_data=%h wr_drop=%b, want %h 0", i, ra, rd_data, wr_drop, exp);
            else n_pass++;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_fill();
        int nb;
        logic seen;
        logic [CW-1:0] v;
        n_chk++;
        if (cmd_ready !== 1'b1) $display("FAIL fill_ready_before: cmd_ready=%b want 1", cmd_ready);
        else n_pass++;
        cmd_op = 2'b01;
        cmd_fill = 12'hA20;
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 4*N; i++) begin
            if (done) begin seen = 1'b1; break; end
            if (busy) nb++;
            if (i == 10) begin
                n_chk++;
                if (cmd_ready !== 1'b0) $display("FAIL fill_ready_busy: cmd_ready=%b want 0", cmd_ready);
                else n_pass++;
            end
            if (i == 51) begin
                n_chk++;
                if (wr_drop !== 1'b1) $display("FAIL wr_drop_pulse: wr_drop=%b want 1", wr_drop);
                else n_pass++;
            end
            if (i == 52) begin
                n_chk++;
                if (wr_drop !== 1'b0) $display("FAIL wr_drop_width: wr_drop=%b want 0", wr_drop);
                else n_pass++;
            end
            wr_en = (i == 50);
            wr_addr = 8'd3;
            wr_data = 12'h123;
            cyc();
        end
        wr_en = 1'b0;
        n_chk++;
        if (!seen || nb != N || busy !== 1'b0) $display("FAIL fill_busy: busy %0d clks done_seen=%b busy_at_done=%b, want %0d 1 0", nb, seen, busy, N);
        else n_pass++;
        cyc();
        n_chk++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL fill_done_width: done=%b cmd_ready=%b want 0 1", done, cmd_ready);
        else n_pass++;
        model_fill(12'hA20);
        for (int i = 0; i < N; i++) begin
            read_cell(AW'(i), v);
            n_chk++;
            if (v !== model[i]) $display("FAIL fill_cell[%0d]: got %h want %h", i, v, model[i]);
            else n_pass++;
        end
    endtask

    task automatic test_rsvd();
        int nb, nd;
        logic bz;
        logic [CW-1:0] v;
        run_cmd(2'b11, 12'hFFF, nb, nd, bz);
        n_chk++;
        if (nb != 0 || nd != 1 || bz !== 1'b0) $display("FAIL rsvd_cmd: busy %0d done %0d busy_at_done %b, want 0 1 0", nb, nd, bz);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            int a;
            a = $urandom_range(0, N-1);
            read_cell(AW'(a), v);
            n_chk++;
            if (v !== model[a]) $display("FAIL rsvd_cell[%0d]: got %h want %h", a, v, model[a]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int nb;
        logic seen;
        logic [CW-1:0] v;
        cmd_op = 2'b01;
        cmd_fill = CW'($urandom_range(1, 4095));
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4*N; i++) begin
            if (done) begin seen = 1'b1; break; end
            cyc();
        end
        n_chk++;
        if (!seen || cmd_ready !== 1'b1) $display("FAIL b2b_ready_in_done: done_seen=%b cmd_ready=%b want 1 1", seen, cmd_ready);
        else n_pass++;
        cmd_op = 2'b00;
        cmd_fill = 12'hFFF;
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 4*N; i++) begin
            if (done) begin seen = 1'b1; break; end
            if (busy) nb++;
            cyc();
        end
        n_chk++;
        if (!seen || nb != N) $display("FAIL b2b_clear_busy: busy %0d clks done_seen=%b, want %0d 1", nb, seen, N);
        else n_pass++;
        model_fill('0);
        for (int i = 0; i < N; i += 7) begin
            read_cell(AW'(i), v);
            n_chk++;
            if (v !== model[i]) $display("FAIL b2b_cell[%0d]: got %h want %h", i, v, model[i]);
            else n_pass++;
        end
    endtask

    task automatic test_scroll_rows();
        int nb, nd;
        logic bz;
        logic [CW-1:0] v;
        for (int i = 0; i < N; i++) begin
            wr_en = 1'b1;
            wr_addr = AW'(i);
            wr_data = CW'(i / W);
            model[i] = CW'(i / W);
            cyc();
        end
        wr_en = 1'b0;
        run_cmd(2'b10, 12'h000, nb, nd, bz);
        n_chk++;
        if (nb != (N - W + 1) + W || nd != 1 || bz !== 1'b0)
            $display("FAIL scroll_busy: busy %0d done %0d busy_at_done %b, want %0d 1 0", nb, nd, bz, N + 1);
        else n_pass++;
        model_scroll(12'h000);
        for (int i = 0; i < N; i++) begin
            read_cell(AW'(i), v);
            n_chk++;
            if (v !== model[i]) $display("FAIL scroll_cell[%0d]: got %h want %h", i, v, model[i]);
            else n_pass++;
        end
    endtask

    task automatic test_scroll_reads();
        int nb, bad;
        logic seen, moved;
        logic [CW-1:0] o0, o1, f, d, v;
        for (int i = 0; i < N; i++) begin
            d = CW'($urandom_range(1, 4095));
            if (i == W) d = (model[0] == 12'hFFF) ? 12'h001 : model[0] + 12'h001;
            wr_en = 1'b1;
            wr_addr = AW'(i);
            wr_data = d;
            model[i] = d;
            cyc();
        end
        wr_en = 1'b0;
        o0 = model[0];
        o1 = model[W];
        f = CW'($urandom);
        rd_addr = '0;
        cmd_op = 2'b10;
        cmd_fill = f;
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        nb = 0;
        bad = 0;
        seen = 1'b0;
        moved = 1'b0;
        for (int i = 0; i < 4*N; i++) begin
            if (rd_data === o1) moved = 1'b1;
            else if (rd_data !== o0 || moved) bad++;
            if (done) begin seen = 1'b1; break; end
            if (busy) nb++;
            cyc();
        end
        n_chk++;
        if (bad != 0 || !moved) $display("FAIL scroll_display_track: bad samples %0d moved=%b, want 0 1 (old %h new %h)", bad, moved, o0, o1);
        else n_pass++;
        n_chk++;
        if (!seen || nb != N + 1) $display("FAIL scroll2_busy: busy %0d done_seen=%b, want %0d 1", nb, seen, N + 1);
        else n_pass++;
        model_scroll(f);
        for (int i = 0; i < N; i++) begin
            read_cell(AW'(i), v);
            n_chk++;
            if (v !== model[i]) $display("FAIL scroll2_cell[%0d]: got %h want %h", i, v, model[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_abort();
        int nd;
        logic [CW-1:0] f, v;
        f = CW'($urandom_range(1, 4095));
        cmd_op = 2'b01;
        cmd_fill = f;
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        nd = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) nd++;
            cyc();
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({busy, done, wr_drop} !== 3'b000 || rd_data !== '0 || nd != 0)
            $display("FAIL abort_outputs: busy=%b done=%b wr_drop=%b rd_data=%h early_done=%0d, want 0 0 0 000 0", busy, done, wr_drop, rd_data, nd);
        else n_pass++;
        for (int i = 0; i < 100; i++) model[i] = f;
        cyc();
        cyc();
        rst = 1'b0;
        rd_addr = '0;
        // Read each cell one clock ahead of the power-up clear sweep to see the aborted state.
        for (int i = 0; i < N; i++) begin
            cyc();
            if (done) nd++;
            n_chk++;
            if (rd_data !== model[i]) $display("FAIL abort_cell[%0d]: got %h want %h", i, rd_data, model[i]);
            else n_pass++;
            rd_addr = AW'(i + 1);
        end
        n_chk++;
        if (nd != 0) $display("FAIL abort_no_done: done pulses %0d want 0", nd);
        else n_pass++;
        cyc();
        n_chk++;
        if (done !== 1'b1) $display("FAIL abort_clear_done: done=%b want 1", done);
        else n_pass++;
        model_fill('0);
        read_cell(8'd200, v);
        n_chk++;
        if (v !== model[200]) $display("FAIL abort_cleared: got %h want %h", v, model[200]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_host_write();
        test_random_rw();
        test_fill();
        test_rsvd();
        test_back_to_back();
        test_scroll_rows();
        test_scroll_reads();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
